// File: rtl/fb_port_arbiter.sv
// Framebuffer BRAM port arbiter: display has strict priority, game and the
// built-in region-clear engine share the remaining cycles round-robin.
module fb_port_arbiter #(
    parameter int              WIDTH   = 1,
    parameter int              LEN     = 16000,
    parameter int              AW      = 14,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_req,
    input  logic [AW-1:0]    d_addr,
    output logic             d_ack,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    input  logic             g_req,
    input  logic             g_we,
    input  logic [AW-1:0]    g_addr,
    input  logic [WIDTH-1:0] g_wdata,
    output logic             g_ack,
    output logic             g_rvalid,
    output logic [WIDTH-1:0] g_rdata,
    input  logic             clr_start,
    input  logic [AW-1:0]    clr_base,
    input  logic [AW:0]      clr_len,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [AW-1:0]    m_addr,
    output logic [WIDTH-1:0] m_din,
    output logic             m_we,
    input  logic [WIDTH-1:0] m_dout
);
    typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_GAME, GNT_CLR} gnt_e;
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;
    typedef enum logic {RR_GAME, RR_CLR} rr_e;

    gnt_e          gnt;
    rr_e           rr;
    clr_state_e    clr_state;
    logic [AW-1:0] clr_ptr;
    logic [AW:0]   clr_rem;
    logic [AW-1:0] addr_q;

    // Nothing is granted while reset is held, so no write can slip through.
    always_comb begin
        gnt = GNT_NONE;
        if (reset) begin
            if (d_req)
                gnt = GNT_DISP;
            else if (g_req && clr_busy)
                gnt = (rr == RR_GAME) ? GNT_GAME : GNT_CLR;
            else if (g_req)
                gnt = GNT_GAME;
            else if (clr_busy)
                gnt = GNT_CLR;
        end
    end

    always_comb begin
        d_ack  = (gnt == GNT_DISP);
        g_ack  = (gnt == GNT_GAME);
        m_addr = addr_q;
        m_din  = '0;
        m_we   = 1'b0;
        case (gnt)
            GNT_DISP: m_addr = d_addr;
            GNT_GAME: begin
                m_addr = g_addr;
                m_din  = g_wdata;
                m_we   = g_we;
            end
            GNT_CLR: begin
                m_addr = clr_ptr;
                m_din  = CLR_VAL;
                m_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // BRAM has one cycle of read latency, so read data passes straight through.
    assign d_rdata = m_dout;
    assign g_rdata = m_dout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_rvalid <= 1'b0;
            g_rvalid <= 1'b0;
            rr       <= RR_GAME;
            addr_q   <= '0;
        end else begin
            d_rvalid <= d_ack;
            g_rvalid <= g_ack & ~g_we;
            if (gnt != GNT_NONE)
                addr_q <= m_addr;
            if (gnt == GNT_GAME)
                rr <= RR_CLR;
            else if (gnt == GNT_CLR)
                rr <= RR_GAME;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_state <= CLR_IDLE;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            clr_ptr   <= '0;
            clr_rem   <= '0;
        end else begin
            clr_done <= 1'b0;
            case (clr_state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        if (clr_len != '0) begin
                            clr_ptr   <= clr_base;
                            clr_rem   <= clr_len;
                            clr_busy  <= 1'b1;
                            clr_state <= CLR_RUN;
                        end else begin
                            clr_done <= 1'b1;
                        end
                    end
                end
                CLR_RUN: begin
                    // clr_start is deliberately ignored here; the running length wins.
                    if (gnt == GNT_CLR) begin
                        clr_ptr <= (clr_ptr == AW'(LEN - 1)) ? '0 : clr_ptr + AW'(1);
                        clr_rem <= clr_rem - (AW+1)'(1);
                        if (clr_rem == (AW+1)'(1)) begin
                            clr_busy  <= 1'b0;
                            clr_done  <= 1'b1;
                            clr_state <= CLR_IDLE;
                        end
                    end
                end
                default: clr_state <= CLR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: bench-side BRAM, a queue-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fb_port_arbiter;
    localparam int               WIDTH   = 1;
    localparam int               LEN     = 16000;
    localparam int               AW      = 14;
    localparam logic [WIDTH-1:0] CLR_VAL = '0;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             d_req = 1'b0;
    logic [AW-1:0]    d_addr = '0;
    logic             d_ack, d_rvalid;
    logic [WIDTH-1:0] d_rdata;
    logic             g_req = 1'b0, g_we = 1'b0;
    logic [AW-1:0]    g_addr = '0;
    logic [WIDTH-1:0] g_wdata = '0;
    logic             g_ack, g_rvalid;
    logic [WIDTH-1:0] g_rdata;
    logic             clr_start = 1'b0;
    logic [AW-1:0]    clr_base = '0;
    logic [AW:0]      clr_len = '0;
    logic             clr_busy, clr_done;
    logic [AW-1:0]    m_addr;
    logic [WIDTH-1:0] m_din;
    logic             m_we;
    logic [WIDTH-1:0] m_dout = '0;

    fb_port_arbiter #(.WIDTH(WIDTH), .LEN(LEN), .AW(AW), .CLR_VAL(CLR_VAL)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_ack(g_ack), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] pat(int i);
        return WIDTH'(i % 3 == 2);
    endfunction

    // Bench BRAM: read-first, one cycle latency.
    logic [WIDTH-1:0] mem [LEN];
    initial begin
        for (int i = 0; i < LEN; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (m_we) mem[m_addr] <= m_din;
            m_dout <= mem[m_addr];
        end
    end

    // Reference model: pending clear addresses as a queue, last non-display winner.
    localparam int W_NONE = 0, W_D = 1, W_G = 2, W_C = 3;
    logic [WIDTH-1:0] mmem [LEN];
    int clr_q[$];
    int wr_log[$];
    int done_cnt = 0, grant_cnt = 0;

    initial begin
        int win, e_addr, last_addr;
        bit idle, e_we, last_game, have_addr;
        bit e_drv, e_grv, e_done;
        int e_drd, e_grd;
        last_game = 0; have_addr = 0; last_addr = 0;
        e_drv = 0; e_grv = 0; e_done = 0; e_drd = 0; e_grd = 0;
        for (int i = 0; i < LEN; i++) mmem[i] = pat(i);
        forever begin
            @(negedge clk);
            idle = (clr_q.size() == 0);
            chk("d_rvalid", d_rvalid, e_drv);
            if (e_drv) chk("d_rdata", d_rdata, e_drd);
            chk("g_rvalid", g_rvalid, e_grv);
            if (e_grv) chk("g_rdata", g_rdata, e_grd);
            chk("clr_busy", clr_busy, !idle);
            chk("clr_done", clr_done, e_done);
            if (clr_done) done_cnt++;

            win = W_NONE;
            if (reset) begin
                if (d_req) win = W_D;
                else if (g_req && !idle) win = last_game ? W_C : W_G;
                else if (g_req) win = W_G;
                else if (!idle) win = W_C;
            end
            chk("d_ack", d_ack, win == W_D);
            chk("g_ack", g_ack, win == W_G);
            e_we = (win == W_G && g_we) || win == W_C;
            chk("m_we", m_we, e_we);
            case (win)
                W_D:     e_addr = d_addr;
                W_G:     e_addr = g_addr;
                W_C:     e_addr = clr_q[0];
                default: e_addr = last_addr;
            endcase
            if (win != W_NONE || have_addr) chk("m_addr", m_addr, e_addr);
            if (e_we) chk("m_din", m_din, (win == W_C) ? CLR_VAL : g_wdata);
            if (m_we) wr_log.push_back(int'(m_addr));
            if (d_ack || g_ack || m_we) grant_cnt++;

            e_drv  = (win == W_D);
            e_drd  = mmem[d_addr];
            e_grv  = (win == W_G) && !g_we;
            e_grd  = mmem[g_addr];
            e_done = 0;
            if (!reset) begin
                clr_q.delete();
                last_game = 0;
                have_addr = 0;
            end else begin
                if (win != W_NONE) begin last_addr = e_addr; have_addr = 1; end
                if (win == W_G) begin
                    last_game = 1;
                    if (g_we) mmem[g_addr] = g_wdata;
                end
                if (win == W_C) begin
                    mmem[clr_q[0]] = CLR_VAL;
                    void'(clr_q.pop_front());
                    last_game = 0;
                    if (clr_q.size() == 0) e_done = 1;
                end
                if (clr_start && idle) begin
                    if (clr_len == '0) e_done = 1;
                    else for (int i = 0; i < int'(clr_len); i++)
                        clr_q.push_back((int'(clr_base) + i) % LEN);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(string n, int d0);
        int c = 0;
        while (done_cnt == d0 && c < 50) begin step(); c++; end
        chk(n, done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, %0d checks so far", checks);
        $fatal(1);
    end

    initial begin
        int g0, d0, l0, reads;
        step(); step();
        chk("rst_busy", clr_busy, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_clr_done", clr_done, 0);
        reset = 1'b1;

        // Display only
        d_req = 1'b1; d_addr = 14'd5; #1;
        chk("disp_ack", d_ack, 1);
        chk("disp_we", m_we, 0);
        chk("disp_addr", m_addr, 5);
        step(); d_req = 1'b0;
        chk("disp_rvalid", d_rvalid, 1);
        chk("disp_rdata", d_rdata, 1);

        // Display vs game write collision
        d_req = 1'b1; d_addr = 14'd3;
        g_req = 1'b1; g_we = 1'b1; g_addr = 14'd7; g_wdata = 1'b1; #1;
        chk("coll_d_ack", d_ack, 1);
        chk("coll_g_ack0", g_ack, 0);
        step(); d_req = 1'b0; #1;
        chk("coll_g_ack1", g_ack, 1);
        step(); g_req = 1'b0; g_we = 1'b0;
        chk("coll_mem7", mem[7], 1);
        chk("coll_g_rvalid", g_rvalid, 0);

        // Clear with game contention: 4 game reads alternate with 4 clear writes
        g0 = grant_cnt; d0 = done_cnt;
        clr_base = 14'd10; clr_len = 15'd4; clr_start = 1'b1;
        step(); clr_start = 1'b0;
        g_req = 1'b1; g_we = 1'b0; g_addr = 14'd20; reads = 0;
        for (int c = 0; c < 40 && !(reads == 4 && done_cnt > d0); c++) begin
            #1;
            if (g_ack) reads++;
            step();
            if (reads >= 4) g_req = 1'b0;
            else g_addr = g_addr + 1'b1;
        end
        chk("cont_reads", reads, 4);
        chk("cont_grants", grant_cnt - g0, 8);
        chk("cont_done", done_cnt - d0, 1);
        for (int a = 10; a <= 13; a++) chk("cont_mem", mem[a], 0);

        // Clear wrapping past the top of the framebuffer
        l0 = wr_log.size(); d0 = done_cnt;
        clr_base = AW'(LEN - 2); clr_len = 15'd3; clr_start = 1'b1;
        step(); clr_start = 1'b0;
        wait_done("wrap_done", d0);
        chk("wrap_nwr", wr_log.size() - l0, 3);
        if (wr_log.size() >= l0 + 3) begin
            chk("wrap_a0", wr_log[l0], LEN - 2);
            chk("wrap_a1", wr_log[l0 + 1], LEN - 1);
            chk("wrap_a2", wr_log[l0 + 2], 0);
        end
        chk("wrap_mem0", mem[0], 0);
        chk("wrap_memtop2", mem[LEN - 2], 0);

        // Zero-length clear
        l0 = wr_log.size(); d0 = done_cnt;
        clr_len = '0; clr_start = 1'b1;
        step(); clr_start = 1'b0;
        chk("zero_done", clr_done, 1);
        chk("zero_busy", clr_busy, 0);
        step(); step();
        chk("zero_nwr", wr_log.size() - l0, 0);
        chk("zero_done_cnt", done_cnt - d0, 1);

        // clr_start while running is ignored
        l0 = wr_log.size(); d0 = done_cnt;
        clr_base = 14'd100; clr_len = 15'd5; clr_start = 1'b1;
        step(); clr_start = 1'b0;
        step();
        clr_base = 14'd200; clr_len = 15'd2; clr_start = 1'b1;
        step(); clr_start = 1'b0;
        wait_done("busy_done", d0);
        repeat (4) step();
        chk("busy_nwr", wr_log.size() - l0, 5);
        if (wr_log.size() >= l0 + 5) begin
            chk("busy_first", wr_log[l0], 100);
            chk("busy_last", wr_log[l0 + 4], 104);
        end
        chk("busy_done_cnt", done_cnt - d0, 1);

        // Reset mid-clear, with the rr pointer left pointing at clear
        l0 = wr_log.size(); d0 = done_cnt;
        clr_base = 14'd300; clr_len = 15'd6; clr_start = 1'b1;
        step(); clr_start = 1'b0;
        step();
        g_req = 1'b1; g_we = 1'b0; g_addr = 14'd50; #1;
        chk("mid_g_ack", g_ack, 1);
        step();
        g_req = 1'b0; d_req = 1'b1; d_addr = 14'd5; reset = 1'b0; #1;
        chk("mid_rst_d_ack", d_ack, 0);
        chk("mid_rst_we", m_we, 0);
        step();
        reset = 1'b1; d_req = 1'b0;
        chk("mid_busy", clr_busy, 0);
        chk("mid_d_rvalid", d_rvalid, 0);
        chk("mid_g_rvalid", g_rvalid, 0);
        repeat (4) step();
        chk("mid_nwr", wr_log.size() - l0, 1);
        chk("mid_no_done", done_cnt - d0, 0);
        chk("mid_mem301", mem[301], pat(301));

        // After reset the rr pointer favours game again
        d0 = done_cnt;
        clr_base = 14'd400; clr_len = 15'd2; clr_start = 1'b1;
        step(); clr_start = 1'b0;
        g_req = 1'b1; g_addr = 14'd60; #1;
        chk("rr_after_rst", g_ack, 1);
        step(); g_req = 1'b0;
        wait_done("rr_done", d0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Arbitrates the single-port framebuffer BRAM among three clients: the display pixel fetch (from the pixel-update path feeding the st7735 driver), the game-logic updater (read/modify/write), and a built-in region-clear engine.
- Sits between the clients and the bram instance and owns its addr/din/we.
- Display gets strict priority; game and clear share the remaining cycles round-robin.

Parameters:
- WIDTH, 1, framebuffer word width.
- LEN, 16000, framebuffer depth in words.
- AW, 14, address width (log2 of LEN-1, rounded up).
- CLR_VAL, 0, word written by the clear engine.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- d_req  in  1  display read request; held until d_ack
- d_addr  in  AW  display read address
- d_ack  out  1  display grant, combinational, this cycle
- d_rvalid  out  1  display read data valid
- d_rdata  out  WIDTH  display read data
- g_req  in  1  game request; held until g_ack
- g_we  in  1  game write (1) / read (0)
- g_addr  in  AW  game address
- g_wdata  in  WIDTH  game write data
- g_ack  out  1  game grant, combinational
- g_rvalid  out  1  game read data valid (reads only)
- g_rdata  out  WIDTH  game read data
- clr_start  in  1  start-clear pulse
- clr_base  in  AW  first address to clear
- clr_len  in  AW+1  number of words to clear
- clr_busy  out  1  clear engine running
- clr_done  out  1  one-cycle completion pulse
- m_addr  out  AW  BRAM address
- m_din  out  WIDTH  BRAM write data
- m_we  out  1  BRAM write enable
- m_dout  in  WIDTH  BRAM read data, valid 1 cycle after address

Behaviour:
- Reset (reset==0 at posedge): d_rvalid, g_rvalid, clr_busy, clr_done = 0; clear FSM -> IDLE; rr pointer -> GAME. m_we = 0 while in reset. An in-flight clear is aborted with no clr_done. A pending rvalid is dropped.
- Grant, evaluated combinationally each cycle, one grant at most:
  - d_req high: grant display.
  - Otherwise, if both game and clear are eligible: grant the rr pointer's client.
  - Otherwise: grant whichever single client is eligible.
  - rr pointer flips to the other client after each game or clear grant. It is unchanged on display grants and idle cycles.
- Eligibility: game = g_req; clear = clr_busy.
- Granted client drives m_addr/m_din/m_we in the same cycle. The matching ack is high that cycle.
- Idle cycle: m_we = 0, m_addr holds its last value.
- Reads: d_rvalid/g_rvalid assert exactly 1 cycle after the ack cycle, with rdata = m_dout. Requester may reassert req the cycle after ack, giving back-to-back throughput of 1 per cycle.
- Game writes: g_ack only, no rvalid. The write lands at the ack-cycle posedge.
- Clear FSM, IDLE -> RUN -> IDLE:
  - IDLE + clr_start with clr_len > 0: latch ptr = clr_base and remaining = clr_len; clr_busy = 1 next cycle.
  - IDLE + clr_start with clr_len == 0: no writes; clr_done pulses the next cycle.
  - RUN, each clear grant: write CLR_VAL at ptr. ptr increments and wraps to 0 after LEN-1. remaining decrements.
  - RUN, grant with remaining == 1: -> IDLE; clr_busy drops and clr_done pulses on the following cycle.
  - clr_start while busy: ignored.
- Same-address conflicts: no hazard checking. Service order is the grant order.
- Starvation bound: game or clear waits at most 1 non-display grant. Display can starve both indefinitely; acceptable because display demand is SPI-paced.

Test Plan:
- Display only: d_req with d_addr=5, mem[5]=1 -> d_ack same cycle, d_rvalid=1 and d_rdata=1 next cycle, m_we=0.
- Display vs game collision: d_req and g_req (write, addr 7, data 1) asserted the same cycle -> d_ack first, g_ack the next cycle; mem[7]=1 afterwards.
- Clear with game contention: clr_base=10, clr_len=4, g_req held for 4 reads -> grants alternate game/clear. mem[10..13]=0 after 4 clear grants; clr_done pulses once; total 8 grant cycles.
- Clear wrap and zero length:
  - clr_base=LEN-2, clr_len=3 -> writes LEN-2, LEN-1, 0.
  - clr_len=0 -> clr_done pulse the next cycle, no m_we.
- Clear start while busy: clr_start during RUN -> ignored, original length honoured.
- Reset mid-clear: reset low for 1 cycle during RUN -> clr_busy=0, no clr_done, no further writes, rvalids 0, rr pointer=GAME.
